mem_access_arbiter: RTL and testbench
=====================================

// Module: mem_access_arbiter
// PURPOSE
//   Shares the 4 x 8-bit byte store between two requesters: port A (switches/store button) and port B (pattern loader/scanner).
//   Owns the storage array, a round-robin arbiter and a 3-state access sequencer. One access in flight at a time.
//   Every request gets a grant pulse; every read gets a registered response. Mirrors one byte onto the LED view port.
// PARAMETERS
//   DATA_W  8  width of one stored byte
//   ADDR_W  2  address width; DEPTH = 2**ADDR_W = 4 entries
// PORTS
//   clk       in   1       system clock; all state changes on rising edge
//   reset_n   in   1       synchronous, active-low reset, sampled on clk rising edge
//   req_a     in   1       port A request; level, held until gnt_a
//   we_a      in   1       port A: 1 = write, 0 = read; sampled with req_a
//   addr_a    in   ADDR_W  port A address
//   wdata_a   in   DATA_W  port A write data
//   gnt_a     out  1       1-cycle pulse: port A access performed this cycle
//   req_b, we_b, addr_b, wdata_b, gnt_b   same as port A, for port B
//   rdata     out  DATA_W  read data, valid only while rvalid=1
//   rvalid    out  1       1-cycle pulse, cycle after a read grant
//   rsel      out  1       owner of rdata/rvalid: 0 = A, 1 = B
//   busy      out  1       1 whenever state != IDLE
//   view_addr in   ADDR_W  byte to mirror on LEDs
//   view_data out  DATA_W  registered copy of mem[view_addr]; 1-cycle lag
// BEHAVIOUR
//   Reset (reset_n=0 at an edge): mem[0..3]=0, gnt_*=0, rvalid=0, rdata=0, rsel=0, busy=0, view_data=0,
//     state=IDLE, last=B (A wins first tie), armed_a=armed_b=1. Reset overrides any access in progress:
//     a write not yet committed is dropped; no gnt/rvalid is issued for it.
//   States: IDLE -> ACCESS -> (RESPOND if read) -> IDLE.
//   IDLE: eligible_x = req_x & armed_x. None eligible: stay. One eligible: latch it.
//     Both eligible: latch the one != last. Latch we/addr/wdata/owner of the winner -> ACCESS.
//   ACCESS (1 cycle): gnt_owner=1. If write: mem[addr] <= wdata. last <= owner; armed_owner <= 0.
//     Write -> IDLE. Read -> RESPOND.
//   RESPOND (1 cycle): rdata = mem[addr], rvalid=1, rsel=owner -> IDLE.
//   Latency: req seen at edge N -> gnt at N+1. Write is visible from N+2. Read rvalid at N+2.
//     Back-to-back: next grant is no earlier than N+3 for a write, N+4 for a read.
//   Re-arm: armed_x <= 1 on any edge where req_x=0. A held req is serviced once only (one button press = one access).
//   Request inputs are sampled only in IDLE. A req dropped before it is latched is ignored.
//     Changes to we/addr/wdata after latching have no effect.
//   Starvation bound: with both ports requesting continuously and re-arming, grants alternate A,B,A,B.
//   view_data <= mem[view_addr] every cycle. A write to the viewed address appears on view_data one cycle after commit.
//   Read-after-write, same address: a read latched after a write's ACCESS cycle returns the new data.
//   gnt_a and gnt_b are never both 1. rvalid is never 1 in the same cycle as any gnt.
// STRUCTURE
//   mem_ctrl_pkg: state encoding (IDLE, ACCESS, RESPOND), DATA_W/ADDR_W defaults, owner constants OWN_A=0, OWN_B=1.
//   Sub-module rr_arbiter2: inputs eligible_a, eligible_b, last; outputs winner and valid (combinational).
//   Top holds the FSM, latched command, storage array, armed flags and view register.
// TESTING
//   1 Reset: hold reset_n=0 3 cycles with req_a=1 -> all outputs 0, no gnt; view_data=0 for all view_addr.
//   2 A write 0xA5 @2, A read @2 -> gnt_a at N+1; rvalid=1, rdata=0xA5, rsel=0 at read+2; view_addr=2 shows 0xA5.
//   3 req_a, req_b rise same edge, both write (A 0x11 @0, B 0x22 @0) -> gnt_a first, then gnt_b; mem[0] ends 0x22.
//   4 Fairness: hold both reqs, pulse each low 1 cycle after its grant -> 8 grants alternate A,B,A,B,...
//   5 Held req: req_a high 20 cycles, write 0x3C @1 -> exactly one gnt_a; a second gnt only after req_a low>=1 cycle.
//   6 Reset mid-op: reset_n=0 during ACCESS of B write 0xFF @3 -> mem[3]=0, no gnt_b, FSM IDLE; next A read @3 -> 0x00.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the two-port byte-store arbiter.
package mem_ctrl_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;
  localparam int NUM_PORTS  = 2;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;
endpackage

// File: rtl/mem_access_arbiter_if.sv
// Request/grant/response bundle between the two requesters and the byte store.
interface mem_access_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              req_a, we_a, gnt_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              req_b, we_b, gnt_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic [DATA_W-1:0] rdata;
  logic              rvalid, rsel, busy;
  logic [ADDR_W-1:0] view_addr;
  logic [DATA_W-1:0] view_data;

  modport master (
    output req_a, we_a, addr_a, wdata_a, req_b, we_b, addr_b, wdata_b, view_addr,
    input  gnt_a, gnt_b, rdata, rvalid, rsel, busy, view_data
  );
  modport slave (
    input  req_a, we_a, addr_a, wdata_a, req_b, we_b, addr_b, wdata_b, view_addr,
    output gnt_a, gnt_b, rdata, rvalid, rsel, busy, view_data
  );
endinterface

// File: rtl/mem_access_arbiter_rr.sv
// Two-way round-robin pick: on a tie the port that did not go last wins.
module rr_arbiter2
  import mem_ctrl_pkg::*;
(
  input  logic eligible_a,
  input  logic eligible_b,
  input  logic last,
  output logic winner,
  output logic valid
);
  always_comb begin
    valid  = eligible_a | eligible_b;
    winner = OWN_A;
    if (eligible_a && eligible_b) winner = ~last;
    else if (eligible_b)          winner = OWN_B;
  end
endmodule

// File: rtl/mem_access_arbiter.sv
// Byte store shared by ports A/B: round-robin arbiter, one-access-at-a-time
// sequencer (IDLE -> ACCESS -> [RESPOND]) and a registered LED view byte.
module mem_access_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic               clk,
  input logic               reset_n,
  mem_access_arbiter_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              own;
  } cmd_t;

  state_t state, state_nxt;
  cmd_t   cmd;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, view_q;
  logic              rsel_q, last;

  logic [NUM_PORTS-1:0]             req, we, armed, elig, gnt;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata;
  logic                             win, win_vld;

  assign req   = {bus.req_b,   bus.req_a};
  assign we    = {bus.we_b,    bus.we_a};
  assign addr  = {bus.addr_b,  bus.addr_a};
  assign wdata = {bus.wdata_b, bus.wdata_a};
  assign elig  = req & armed;

  rr_arbiter2 u_arb (
    .eligible_a (elig[OWN_A]),
    .eligible_b (elig[OWN_B]),
    .last       (last),
    .winner     (win),
    .valid      (win_vld)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = ACCESS;
      ACCESS:  state_nxt = cmd.we ? IDLE : RESPOND;
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Command is frozen at latch time; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!reset_n)                    cmd <= '0;
    else if (state == IDLE && win_vld)
      cmd <= '{we: we[win], addr: addr[win], wdata: wdata[win], own: win};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == ACCESS && cmd.we) begin
      mem[cmd.addr] <= cmd.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_q <= '0;
      rsel_q  <= OWN_A;
    end else if (state == ACCESS && !cmd.we) begin
      rdata_q <= mem[cmd.addr];
      rsel_q  <= cmd.own;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)              last <= OWN_B;
    else if (state == ACCESS)  last <= cmd.own;
  end

  // A released request re-arms even on its own grant edge, so one press = one access.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!reset_n || !req[p])                                armed[p] <= 1'b1;
      else if (state == ACCESS && cmd.own == 1'(p))           armed[p] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) view_q <= '0;
    else          view_q <= mem[bus.view_addr];
  end

  // Qualified by reset_n: an access cancelled by reset is never reported.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_gnt
    assign gnt[p] = reset_n && (state == ACCESS) && (cmd.own == 1'(p));
  end

  assign bus.gnt_a     = gnt[OWN_A];
  assign bus.gnt_b     = gnt[OWN_B];
  assign bus.rvalid    = reset_n && (state == RESPOND);
  assign bus.rdata     = rdata_q;
  assign bus.rsel      = rsel_q;
  assign bus.busy      = (state != IDLE);
  assign bus.view_data = view_q;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Random + directed bench for mem_access_arbiter with a timeline-based reference model.
module tb_mem_access_arbiter;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_arbiter_if #(.DATA_W(8), .ADDR_W(2)) bus ();
  mem_access_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: schedules each accepted request on an edge timeline
  // (grant N+1, commit N+1, response N+2, arbiter free N+2 write / N+3 read).
  int   ecnt = 0, free_edge = 0, acc_edge = 0;
  bit   acc_pend = 0;
  logic [7:0] mem_m [4];
  logic       last_m;
  logic [1:0] armed_m, m_req, m_clr, m_elig;
  logic       m_win, c_we, c_own;
  logic [1:0] c_addr;
  logic [7:0] c_wdata;
  logic e_gnt_a = 0, e_gnt_b = 0, e_rv = 0, e_rsel = 0, e_busy = 0;
  logic [7:0] e_rdata = 0, e_view = 0;

  initial forever begin
    @(posedge clk);
    ecnt++;
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) mem_m[i] = 8'h00;
      last_m = OWN_B; armed_m = 2'b11; acc_pend = 0; free_edge = ecnt + 1;
      e_gnt_a = 0; e_gnt_b = 0; e_rv = 0; e_rsel = 0; e_busy = 0; e_rdata = 0; e_view = 0;
    end else begin
      m_req  = {bus.req_b, bus.req_a};
      m_clr  = 2'b00;
      e_view = mem_m[bus.view_addr];
      e_gnt_a = 0; e_gnt_b = 0; e_rv = 0;
      if (acc_pend && acc_edge == ecnt) begin
        acc_pend = 0; last_m = c_own; m_clr[c_own] = 1'b1;
        if (c_we) mem_m[c_addr] = c_wdata;
        else begin e_rdata = mem_m[c_addr]; e_rsel = c_own; e_rv = 1; end
      end
      m_elig = m_req & armed_m;
      if (ecnt >= free_edge && m_elig != 2'b00) begin
        m_win   = (m_elig == 2'b11) ? !last_m : m_elig[1];
        c_own   = m_win;
        c_we    = m_win ? bus.we_b    : bus.we_a;
        c_addr  = m_win ? bus.addr_b  : bus.addr_a;
        c_wdata = m_win ? bus.wdata_b : bus.wdata_a;
        acc_pend = 1; acc_edge = ecnt + 1; free_edge = ecnt + (c_we ? 2 : 3);
        if (m_win) e_gnt_b = 1; else e_gnt_a = 1;
      end
      for (int p = 0; p < 2; p++)
        if (!m_req[p]) armed_m[p] = 1'b1; else if (m_clr[p]) armed_m[p] = 1'b0;
      e_busy = (ecnt + 1 < free_edge);
    end
  end

  // Per-cycle compare, mid-cycle, after stimulus has settled.
  initial forever begin
    @(negedge clk);
    if (ecnt > 0) begin
      chk("gnt_a",  bus.gnt_a,     e_gnt_a & reset_n);
      chk("gnt_b",  bus.gnt_b,     e_gnt_b & reset_n);
      chk("rvalid", bus.rvalid,    e_rv & reset_n);
      chk("busy",   bus.busy,      e_busy);
      chk("view",   bus.view_data, e_view);
      chk("gnt_excl", bus.gnt_a & bus.gnt_b, 1'b0);
      chk("rv_vs_gnt", bus.rvalid & (bus.gnt_a | bus.gnt_b), 1'b0);
      if (e_rv && reset_n) begin
        chk("rdata", bus.rdata, e_rdata);
        chk("rsel",  bus.rsel,  e_rsel);
      end
    end
  end

  task automatic step(); @(posedge clk); #1; endtask

  task automatic drive(input logic p, input logic r, input logic w, input logic [1:0] a, input logic [7:0] d);
    if (!p) begin bus.req_a = r; bus.we_a = w; bus.addr_a = a; bus.wdata_a = d; end
    else    begin bus.req_b = r; bus.we_b = w; bus.addr_b = a; bus.wdata_b = d; end
  endtask

  task automatic set_req(input logic p, input logic r);
    if (!p) bus.req_a = r; else bus.req_b = r;
  endtask

  function automatic logic gnt_of(input logic p);
    return p ? bus.gnt_b : bus.gnt_a;
  endfunction

  task automatic reset_seq();
    reset_n = 1'b0; set_req(0, 0); set_req(1, 0);
    step(); step();
    reset_n = 1'b1;
  endtask

  // One access from idle: returns grant latency and (for reads) response fields.
  task automatic do_access(input logic p, input logic w, input logic [1:0] a, input logic [7:0] d,
                           output int lat, output logic rv, output logic [7:0] rd, output logic rs);
    drive(p, 1, w, a, d); lat = 0; rv = 0; rd = 0; rs = 0;
    do begin step(); lat++; end while (!gnt_of(p) && lat < 20);
    chk("gnt_wait", gnt_of(p), 1'b1);
    set_req(p, 0);
    if (!w) begin step(); rv = bus.rvalid; rd = bus.rdata; rs = bus.rsel; end
    step();
  endtask

  int lat, cnt;
  logic rv, rs;
  logic [7:0] rd;
  int order [$];

  initial begin
    bus.view_addr = 2'd0;
    drive(0, 1, 0, 2'd0, 8'h00);
    drive(1, 0, 0, 2'd0, 8'h00);

    // Reset held with req_a high: nothing granted, all views zero.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_gnt_a", bus.gnt_a, 1'b0);
      chk("rst_view",  bus.view_data, 8'h00);
      chk("rst_rdata", bus.rdata, 8'h00);
      chk("rst_busy",  bus.busy, 1'b0);
      bus.view_addr = 2'(i);
    end
    set_req(0, 0); step(); reset_n = 1'b1;

    // Write then read back through port A.
    do_access(0, 1, 2'd2, 8'hA5, lat, rv, rd, rs);
    chk("wr_lat", lat, 1);
    do_access(0, 0, 2'd2, 8'h00, lat, rv, rd, rs);
    chk("rd_lat", lat, 1);
    chk("rd_rvalid", rv, 1'b1);
    chk("rd_data", rd, 8'hA5);
    chk("rd_rsel", rs, OWN_A);
    bus.view_addr = 2'd2; step();
    chk("view_a5", bus.view_data, 8'hA5);
    chk("model_mem2", mem_m[2], 8'hA5);

    // Simultaneous writes to the same byte: A first after reset, B overwrites.
    reset_seq();
    drive(0, 1, 1, 2'd0, 8'h11); drive(1, 1, 1, 2'd0, 8'h22);
    order.delete();
    for (int i = 0; i < 20 && order.size() < 2; i++) begin
      step();
      if (bus.gnt_a) begin order.push_back(0); set_req(0, 0); end
      if (bus.gnt_b) begin order.push_back(1); set_req(1, 0); end
    end
    chk("tie_count", order.size(), 2);
    if (order.size() == 2) begin chk("tie_first", order[0], 0); chk("tie_second", order[1], 1); end
    step(); step();
    do_access(1, 0, 2'd0, 8'h00, lat, rv, rd, rs);
    chk("tie_mem0", rd, 8'h22);
    chk("tie_rsel", rs, OWN_B);

    // Fairness: both held, each released for one cycle after its grant.
    reset_seq();
    drive(0, 1, 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 8'($urandom_range(255, 0)));
    drive(1, 1, 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 8'($urandom_range(255, 0)));
    order.delete();
    for (int i = 0; i < 80 && order.size() < 8; i++) begin
      step();
      for (int p = 0; p < 2; p++) begin
        if (gnt_of(1'(p))) begin order.push_back(p); set_req(1'(p), 0); end
        else if (!(p ? bus.req_b : bus.req_a))
          drive(1'(p), 1, 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 8'($urandom_range(255, 0)));
      end
    end
    chk("fair_count", order.size(), 8);
    foreach (order[i]) chk("fair_order", order[i], i % 2);
    set_req(0, 0); set_req(1, 0);
    for (int i = 0; i < 4; i++) step();

    // Held request: exactly one grant until released.
    drive(0, 1, 1, 2'd1, 8'h3C); cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); if (bus.gnt_a) cnt++; end
    chk("held_once", cnt, 1);
    set_req(0, 0); step(); set_req(0, 1); cnt = 0;
    for (int i = 0; i < 10; i++) begin step(); if (bus.gnt_a) cnt++; end
    chk("rearm_once", cnt, 1);
    chk("model_mem1", mem_m[1], 8'h3C);
    set_req(0, 0); step(); step();

    // Reset lands on the ACCESS edge of a B write: dropped.
    reset_seq();
    drive(1, 1, 1, 2'd3, 8'hFF); step();
    chk("pre_rst_busy", bus.busy, 1'b1);
    reset_n = 1'b0; set_req(1, 0);
    step(); reset_n = 1'b1;
    chk("post_rst_busy", bus.busy, 1'b0);
    do_access(0, 0, 2'd3, 8'h00, lat, rv, rd, rs);
    chk("rst_drop_rd", rd, 8'h00);
    chk("model_mem3", mem_m[3], 8'h00);

    // Random traffic with occasional resets.
    for (int c = 0; c < 500; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!(p ? bus.req_b : bus.req_a)) begin
          if ($urandom_range(1, 0) == 1)
            drive(1'(p), 1, 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 8'($urandom_range(255, 0)));
        end else if (gnt_of(1'(p))) begin
          if ($urandom_range(3, 0) != 0) set_req(1'(p), 0);
        end else if ($urandom_range(15, 0) == 0) begin
          set_req(1'(p), 0);
        end
      end
      bus.view_addr = 2'($urandom_range(3, 0));
      reset_n = ($urandom_range(63, 0) != 0);
      step();
    end
    reset_n = 1'b1; set_req(0, 0); set_req(1, 0);
    for (int i = 0; i < 4; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
